// File: rtl/mem_stage_ctrl_pkg.sv
// Shared MIPS types: data word, memory control word and access size codes.
package mips_typedef;

  typedef logic [31:0] word_t;

  // {unsigned_ld, size, write, en}; bit order matches the 5-bit ctrl buses
  typedef struct packed {
    logic       unsigned_ld;
    logic [1:0] size;
    logic       write;
    logic       en;
  } mem_ctrl_t;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b11;
  localparam logic [1:0] SZ_BAD = 2'b10;

  // The only unencoded size is 2'b10; everything else reaches the RAM.
  function automatic logic size_legal(input mem_ctrl_t c);
    return c.size != SZ_BAD;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_perf_cnt.sv
// Load/store retirement counters and the sticky illegal-size flag.
module mem_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_stb,
  input  logic             store_stb,
  input  logic             err_stb,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt,
  output logic             size_err
);

  // Free-running wrap-around counters; size_err only clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt  <= '0;
      store_cnt <= '0;
      size_err  <= 1'b0;
    end else begin
      if (load_stb)  load_cnt  <= load_cnt + CNT_W'(1);
      if (store_stb) store_cnt <= store_cnt + CNT_W'(1);
      if (err_stb)   size_err  <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: S1 issues the RAM access, S2 holds the result for WB.
module mem_stage_ctrl
  import mips_typedef::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [4:0]        ex_mem_ctrl,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_wr_data,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_rd_we,
  output logic [4:0]        ram_ctrl,
  output logic [31:0]       ram_addr,
  output logic [31:0]       ram_wr_data,
  input  logic [31:0]       ram_rd_data,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [31:0]       wb_data,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_rd_we,
  output logic              size_err,
  output logic [CNT_W-1:0]  load_cnt,
  output logic [CNT_W-1:0]  store_cnt
);

  // vld_pipe[1] = S1 (issue), vld_pipe[2] = S2 (result)
  logic [2:1]        vld_pipe;
  mem_ctrl_t         s1_ctrl, s2_ctrl;
  word_t             s1_addr, s1_wdata, s2_addr, s2_data_q;
  logic [REG_AW-1:0] s1_rd, s2_rd;
  logic              s1_rd_we, s2_rd_we;
  logic              s2_fresh;

  logic s2_accept, s1_adv, s1_legal, s2_legal, s1_is_load, s2_is_load;

  assign s2_accept  = ~vld_pipe[2] | wb_ready;
  assign s1_adv     = vld_pipe[1] & s2_accept;
  assign ex_ready   = ~vld_pipe[1] | s1_adv;
  assign s1_legal   = size_legal(s1_ctrl);
  assign s2_legal   = size_legal(s2_ctrl);
  assign s1_is_load = s1_ctrl.en & ~s1_ctrl.write;
  assign s2_is_load = s2_ctrl.en & ~s2_ctrl.write;

  // RAM sees an enable only in the one cycle S1 advances, so stalls never re-issue.
  assign ram_ctrl    = (s1_adv & s1_ctrl.en & s1_legal) ? s1_ctrl : '0;
  assign ram_addr    = s1_addr;
  assign ram_wr_data = s1_wdata;

  assign wb_valid = vld_pipe[2];
  assign wb_rd    = s2_rd;
  assign wb_rd_we = vld_pipe[2] & s2_rd_we & ~(s2_ctrl.en & s2_ctrl.write);

  // Pipeline registers; s2_fresh marks the cycle RAM read data is live on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      s1_ctrl   <= '0;
      s1_addr   <= '0;
      s1_wdata  <= '0;
      s1_rd     <= '0;
      s1_rd_we  <= 1'b0;
      s2_ctrl   <= '0;
      s2_addr   <= '0;
      s2_rd     <= '0;
      s2_rd_we  <= 1'b0;
      s2_fresh  <= 1'b0;
      s2_data_q <= '0;
    end else begin
      if (ex_ready) begin
        vld_pipe[1] <= ex_valid;
        if (ex_valid) begin
          s1_ctrl  <= mem_ctrl_t'(ex_mem_ctrl);
          s1_addr  <= ex_addr;
          s1_wdata <= ex_wr_data;
          s1_rd    <= ex_rd;
          s1_rd_we <= ex_rd_we;
        end
      end
      if (s2_accept) vld_pipe[2] <= vld_pipe[1];
      // Capture read data the cycle it arrives; held loads then read s2_data_q.
      if (s2_fresh) s2_data_q <= ram_rd_data;
      if (s1_adv) begin
        s2_ctrl  <= s1_ctrl;
        s2_addr  <= s1_addr;
        s2_rd    <= s1_rd;
        s2_rd_we <= s1_rd_we;
        s2_fresh <= s1_is_load & s1_legal;
      end else if (s2_fresh) begin
        s2_fresh <= 1'b0;
      end
    end
  end

  // Result mux: legal loads return RAM data, illegal ops 0, everything else the address.
  always_comb begin
    wb_data = '0;
    if (vld_pipe[2]) begin
      if (s2_ctrl.en && !s2_legal) wb_data = '0;
      else if (s2_is_load)         wb_data = s2_fresh ? ram_rd_data : s2_data_q;
      else                         wb_data = s2_addr;
    end
  end

  mem_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_stb  (wb_valid & wb_ready & s2_is_load & s2_legal),
    .store_stb (s1_adv & s1_ctrl.en & s1_ctrl.write & s1_legal),
    .err_stb   (s1_adv & s1_ctrl.en & ~s1_legal),
    .load_cnt  (load_cnt),
    .store_cnt (store_cnt),
    .size_err  (size_err)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a byte-addressed sync-read RAM model
// and an in-order scoreboard of expected WB results.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [4:0]  ex_mem_ctrl;
  logic [31:0] ex_addr, ex_wr_data;
  logic [4:0]  ex_rd;
  logic        ex_rd_we;
  logic [4:0]  ram_ctrl;
  logic [31:0] ram_addr, ram_wr_data, ram_rd_data;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_rd_we, size_err;
  logic [31:0] load_cnt, store_cnt;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_mem_ctrl(ex_mem_ctrl),
    .ex_addr(ex_addr), .ex_wr_data(ex_wr_data), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .ram_ctrl(ram_ctrl), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_rd_we(wb_rd_we), .size_err(size_err), .load_cnt(load_cnt), .store_cnt(store_cnt)
  );

  // RAM model: little-endian bytes, extension done here; bus is junk when not reading
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_ctrl[0] && ram_ctrl[1]) begin
      mem[ram_addr[7:0]] <= ram_wr_data[7:0];
      if (ram_ctrl[3:2] != 2'b00) mem[8'(ram_addr[7:0] + 8'd1)] <= ram_wr_data[15:8];
      if (ram_ctrl[3:2] == 2'b11) begin
        mem[8'(ram_addr[7:0] + 8'd2)] <= ram_wr_data[23:16];
        mem[8'(ram_addr[7:0] + 8'd3)] <= ram_wr_data[31:24];
      end
      ram_rd_data <= 32'hBADBAD00;
    end else if (ram_ctrl[0]) begin
      case (ram_ctrl[3:2])
        2'b00:   ram_rd_data <= ram_ctrl[4] ? {24'h0, mem[ram_addr[7:0]]}
                                            : {{24{mem[ram_addr[7:0]][7]}}, mem[ram_addr[7:0]]};
        2'b01:   ram_rd_data <= ram_ctrl[4]
                   ? {16'h0, mem[8'(ram_addr[7:0] + 8'd1)], mem[ram_addr[7:0]]}
                   : {{16{mem[8'(ram_addr[7:0] + 8'd1)][7]}}, mem[8'(ram_addr[7:0] + 8'd1)], mem[ram_addr[7:0]]};
        default: ram_rd_data <= {mem[8'(ram_addr[7:0] + 8'd3)], mem[8'(ram_addr[7:0] + 8'd2)],
                                 mem[8'(ram_addr[7:0] + 8'd1)], mem[ram_addr[7:0]]};
      endcase
    end else begin
      ram_rd_data <= 32'hBADBAD00;
    end
  end

  typedef struct {
    logic [4:0]  rd;
    logic        rd_we;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   ram_acc = 0;
  logic [4:0] last_ram_ctrl = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Sampled on the falling edge: count RAM enables, retire WB results against the scoreboard.
  task automatic monitor();
    exp_t e;
    if (ram_ctrl[0]) begin
      ram_acc++;
      last_ram_ctrl = ram_ctrl;
    end
    if (wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
        chk("wb_rd_we", 32'(wb_rd_we), 32'(e.rd_we));
        if (e.chk_data) chk("wb_data", wb_data, e.data);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [4:0] c, input logic [31:0] a, input logic [31:0] wd,
                      input logic [4:0] rd, input logic we, input logic cd, input logic [31:0] xd);
    exp_t e;
    logic acc;
    e.rd = rd; e.rd_we = we; e.chk_data = cd; e.data = xd;
    ex_valid = 1'b1; ex_mem_ctrl = c; ex_addr = a; ex_wr_data = wd; ex_rd = rd; ex_rd_we = we;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      monitor();
      acc = ex_ready;
      if (acc) exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    ex_valid = 1'b0;
  endtask

  int acc0;

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_mem_ctrl = '0; ex_addr = '0; ex_wr_data = '0;
    ex_rd = '0; ex_rd_we = 1'b0; wb_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_ram_ctrl", 32'(ram_ctrl), 32'd0);
    chk("rst_cnts", load_cnt | store_cnt | 32'(size_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: sw then lw to the same word, no forwarding needed
    acc0 = ram_acc;
    send(5'b01111, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 32'h0);
    send(5'b01101, 32'h10, 32'h0, 5'd3, 1'b1, 1'b1, 32'hDEADBEEF);
    idle(4);
    chk("t1_ram_acc", 32'(ram_acc - acc0), 32'd2);
    chk("t1_last_ctrl", 32'(last_ram_ctrl), 32'b01101);

    // 2: byte/half sign and zero extension
    send(5'b00011, 32'h21, 32'h00000080, 5'd0, 1'b0, 1'b0, 32'h0);
    send(5'b00111, 32'h24, 32'h00008001, 5'd0, 1'b0, 1'b0, 32'h0);
    send(5'b00001, 32'h21, 32'h0, 5'd4, 1'b1, 1'b1, 32'hFFFFFF80);
    send(5'b10001, 32'h21, 32'h0, 5'd5, 1'b1, 1'b1, 32'h00000080);
    send(5'b00101, 32'h24, 32'h0, 5'd6, 1'b1, 1'b1, 32'hFFFF8001);
    idle(4);
    chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // 3: stall with both stages full, load data must hold and RAM stay idle
    wb_ready = 1'b0;
    send(5'b01101, 32'h10, 32'h0, 5'd6, 1'b1, 1'b1, 32'hDEADBEEF);
    send(5'b00000, 32'h1234, 32'h0, 5'd7, 1'b1, 1'b1, 32'h1234);
    ex_valid = 1'b1; ex_mem_ctrl = 5'b01101; ex_addr = 32'h10; ex_rd = 5'd8; ex_rd_we = 1'b1;
    acc0 = ram_acc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      monitor();
      chk("t3_ex_ready", 32'(ex_ready), 32'd0);
      chk("t3_ram_ctrl", 32'(ram_ctrl), 32'd0);
      chk("t3_wb_valid", 32'(wb_valid), 32'd1);
      chk("t3_wb_data", wb_data, 32'hDEADBEEF);
      @(posedge clk);
      #1;
    end
    chk("t3_no_reread", 32'(ram_acc - acc0), 32'd0);
    wb_ready = 1'b1;
    send(5'b01101, 32'h10, 32'h0, 5'd8, 1'b1, 1'b1, 32'hDEADBEEF);
    idle(4);
    chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // 4: back-to-back sw, lw, lw, add at full throughput
    acc0 = ram_acc;
    send(5'b01111, 32'h40, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 32'h0);
    send(5'b01101, 32'h40, 32'h0, 5'd9, 1'b1, 1'b1, 32'hCAFEF00D);
    send(5'b01101, 32'h10, 32'h0, 5'd10, 1'b1, 1'b1, 32'hDEADBEEF);
    send(5'b00000, 32'h55, 32'h0, 5'd11, 1'b1, 1'b1, 32'h55);
    idle(4);
    chk("t4_ram_acc", 32'(ram_acc - acc0), 32'd3);
    chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // 5: illegal size retires with data 0, no RAM access, sticky error
    acc0 = ram_acc;
    send(5'b01001, 32'h10, 32'h0, 5'd12, 1'b1, 1'b1, 32'h0);
    idle(3);
    chk("t5_no_ram", 32'(ram_acc - acc0), 32'd0);
    chk("t5_size_err", 32'(size_err), 32'd1);
    send(5'b00000, 32'h77, 32'h0, 5'd13, 1'b1, 1'b1, 32'h77);
    idle(3);
    chk("t5_sticky", 32'(size_err), 32'd1);
    chk("t5_store_cnt", store_cnt, 32'd4);
    chk("t5_load_cnt", load_cnt, 32'd8);

    // 6: reset while a store waits in S1 must drop it
    send(5'b01111, 32'h60, 32'h11223344, 5'd0, 1'b0, 1'b0, 32'h0);
    idle(3);
    wb_ready = 1'b0;
    send(5'b00000, 32'h99, 32'h0, 5'd13, 1'b1, 1'b1, 32'h99);
    send(5'b01111, 32'h60, 32'h99999999, 5'd0, 1'b0, 1'b0, 32'h0);
    acc0 = ram_acc;
    rst_n = 1'b0;
    #1;
    chk("t6_ram_ctrl", 32'(ram_ctrl), 32'd0);
    chk("t6_ex_ready", 32'(ex_ready), 32'd1);
    chk("t6_wb_valid", 32'(wb_valid), 32'd0);
    chk("t6_wb_data", wb_data, 32'd0);
    chk("t6_wb_rd", 32'(wb_rd) | 32'(wb_rd_we), 32'd0);
    chk("t6_cnts", load_cnt | store_cnt | 32'(size_err), 32'd0);
    exp_q.delete();
    wb_ready = 1'b1;
    idle(2);
    chk("t6_no_write", 32'(ram_acc - acc0), 32'd0);
    rst_n = 1'b1;
    tick();
    send(5'b01101, 32'h60, 32'h0, 5'd14, 1'b1, 1'b1, 32'h11223344);
    idle(4);
    chk("t6_load_cnt", load_cnt, 32'd1);
    chk("t6_store_cnt", store_cnt, 32'd0);
    chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
